ram_arbiter: RTL and testbench

- N-requester arbiter in front of one single-port, 1-cycle-latency SoC RAM. Generalises the two-port priority mux: port 0 (core data side) keeps priority, and ports 1..N-1 (debug, DMA, peripherals) share the remaining slots round-robin.
- A starvation guard bounds how long port 0 can hold the RAM under contention.
- Generates per-port rvalid and broadcasts read data.

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter_rr_pick.sv | 46 ++++
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the SoC RAM arbiter and its round-robin picker.
package ram_arbiter_pkg;

    localparam int MAX_PORTS = 16;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    localparam port_idx_t RR_PTR_RESET = port_idx_t'(1);

    // Counter width able to hold values 0..v-1, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Round-robin picker over ports 1..NUM_PORTS-1; port 0 is never a candidate.
module ram_arbiter_rr_pick
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output port_idx_t            idx
);

    logic      hi_hit, lo_hit;
    port_idx_t hi_idx, lo_idx;
    logic      unused_req0;

    assign unused_req0 = req[0];

    // Descending scan leaves the lowest requester at/above ptr in hi_idx and
    // the lowest requester overall in lo_idx (the wrap-around winner).
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = NUM_PORTS-1; i >= 1; i--) begin
            if (req[i]) begin
                lo_hit = 1'b1;
                lo_idx = port_idx_t'(i);
                if (port_idx_t'(i) >= ptr) begin
                    hi_hit = 1'b1;
                    hi_idx = port_idx_t'(i);
                end
            end
        end
    end

    assign idx = hi_hit ? hi_idx : lo_idx;

    always_comb begin
        gnt = '0;
        for (int i = 1; i < NUM_PORTS; i++)
            gnt[i] = (hi_hit | lo_hit) & (port_idx_t'(i) == idx);
    end

endmodule

// File: rtl/ram_arbiter.sv
// N-port arbiter for a single-port 1-cycle RAM: port 0 priority with starvation guard,
// round-robin among the rest. Define RAM_ARBITER_PERF_CNT_EN for the contention counter.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int HOLD_MAX   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              req_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic                              ram_en_o,
    output logic [ADDR_WIDTH-1:0]             ram_addr_o,
    output logic                              ram_we_o,
    output logic [DATA_WIDTH/8-1:0]           ram_be_o,
    output logic [DATA_WIDTH-1:0]             ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]             ram_rdata_i,
    output logic [31:0]                       conflict_cnt_o
);

    localparam int BE_W     = DATA_WIDTH/8;
    localparam int STREAK_W = clog2_min1(HOLD_MAX+1);

    logic [STREAK_W-1:0]  streak_q;
    port_idx_t            rr_ptr_q;
    logic [NUM_PORTS-1:0] rvalid_q;
    logic [NUM_PORTS-1:0] rr_gnt;
    port_idx_t            rr_idx;
    logic                 contended, force_rr;

    assign contended = req_i[0] & (|req_i[NUM_PORTS-1:1]);
    assign force_rr  = (HOLD_MAX > 0) && contended && (streak_q == STREAK_W'(HOLD_MAX));

    ram_arbiter_rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
        .req (req_i),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt),
        .idx (rr_idx)
    );

    always_comb begin
        gnt_o = '0;
        if (!rst) begin
            if (force_rr)      gnt_o = rr_gnt;
            else if (req_i[0]) gnt_o[0] = 1'b1;
            else               gnt_o = rr_gnt;
        end
    end

    // One-hot grant lets the payload mux be a plain AND-OR; zero grant gives zero outputs.
    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            ram_addr_o  = ram_addr_o  | (addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_o[k]}});
            ram_we_o    = ram_we_o    | (we_i[k] & gnt_o[k]);
            ram_be_o    = ram_be_o    | (be_i[k*BE_W +: BE_W] & {BE_W{gnt_o[k]}});
            ram_wdata_o = ram_wdata_o | (wdata_i[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_o[k]}});
        end
    end

    assign ram_en_o = |gnt_o;
    assign rdata_o  = ram_rdata_i;
    // Masking with rst drops a response that would land while reset is asserted.
    assign rvalid_o = rst ? '0 : rvalid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
            rr_ptr_q <= RR_PTR_RESET;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt_o;
            if (|gnt_o[NUM_PORTS-1:1])
                rr_ptr_q <= (rr_idx == port_idx_t'(NUM_PORTS-1)) ? RR_PTR_RESET : rr_idx + 1'b1;
            if ((HOLD_MAX > 0) && contended && gnt_o[0])
                streak_q <= streak_q + 1'b1;
            else
                streak_q <= '0;
        end
    end

`ifdef RAM_ARBITER_PERF_CNT_EN
    logic [31:0] conflict_cnt_q;
    logic        starved;

    assign starved = |(req_i & ~gnt_o);

    always_ff @(posedge clk) begin
        if (rst)
            conflict_cnt_q <= '0;
        else if ((contended | starved) && (conflict_cnt_q != '1))
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end

    assign conflict_cnt_o = conflict_cnt_q;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: HOLD_MAX=4 and strict-priority (HOLD_MAX=0) instances.
module tb_ram_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW/8;

`ifdef RAM_ARBITER_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] req = '0;
    logic [NP-1:0] we = '0;
    logic [NP*AW-1:0] addr = '0;
    logic [NP*BW-1:0] be = '0;
    logic [NP*DW-1:0] wdata = '0;
    logic [DW-1:0] ram_rdata = '0;

    logic [NP-1:0] gnt, rvalid, gnt_z, rvalid_z;
    logic [DW-1:0] rdata, rdata_z, ram_wdata, ram_wdata_z;
    logic [AW-1:0] ram_addr, ram_addr_z;
    logic [BW-1:0] ram_be, ram_be_z;
    logic          ram_en, ram_we, ram_en_z, ram_we_z;
    logic [31:0]   cnt, cnt_z;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt), .rvalid_o(rvalid),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .conflict_cnt_o(cnt)
    );

    ram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOLD_MAX(0)) dut_z (
        .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt_z), .rvalid_o(rvalid_z),
        .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata), .rdata_o(rdata_z),
        .ram_en_o(ram_en_z), .ram_addr_o(ram_addr_z), .ram_we_o(ram_we_z), .ram_be_o(ram_be_z),
        .ram_wdata_o(ram_wdata_z), .ram_rdata_i(ram_rdata), .conflict_cnt_o(cnt_z)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int exp2 [9] = '{0, 0, 0, 0, 2, 0, 0, 0, 0};
    int exp3 [6] = '{1, 2, 3, 1, 2, 3};

    initial begin
        // Reset: requests ignored, everything idle.
        req = 4'b1111;
        @(negedge clk);
        chk("rst gnt", gnt, 0);
        chk("rst ram_en", ram_en, 0);
        chk("rst rvalid", rvalid, 0);
        chk("rst streak", dut.streak_q, 0);
        chk("rst rr_ptr", dut.rr_ptr_q, 1);
        chk("rst cnt", cnt, 0);

        // Port 1 read at 0x100.
        step();
        rst = 1'b0;
        req = 4'b0010;
        addr[1*AW +: AW] = 32'h100;
        @(negedge clk);
        chk("t1 gnt", gnt, 4'b0010);
        chk("t1 ram_en", ram_en, 1);
        chk("t1 ram_addr", ram_addr, 32'h100);
        chk("t1 ram_we", ram_we, 0);
        step();
        req = '0;
        ram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1 rvalid", rvalid, 4'b0010);
        chk("t1 rdata", rdata, 32'hDEADBEEF);
        chk("t1 idle gnt", gnt, 0);
        chk("t1 rr_ptr", dut.rr_ptr_q, 2);

        // Ports 0 and 2 held: starvation guard forces port 2 after four port-0 grants.
        step();
        addr[0*AW +: AW] = 32'h40;
        addr[2*AW +: AW] = 32'h2200;
        req = 4'b0101;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("t2 gnt c%0d", i), gnt, 64'(1) << exp2[i]);
            chk($sformatf("t2 gnt_z c%0d", i), gnt_z, 4'b0001);
            if (i == 0) chk("t2 addr port0", ram_addr, 32'h40);
            if (i == 4) begin
                chk("t2 streak pre", dut.streak_q, 4);
                chk("t2 addr forced", ram_addr, 32'h2200);
            end
            if (i == 5) begin
                chk("t2 streak post", dut.streak_q, 0);
                chk("t2 rr_ptr", dut.rr_ptr_q, 3);
            end
            step();
        end
        req = '0;

        // Ports 1..3 rotate from a fresh pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t3 gnt c%0d", i), gnt, 64'(1) << exp3[i]);
            chk($sformatf("t3 gnt_z c%0d", i), gnt_z, 64'(1) << exp3[i]);
            if (i == 3) chk("t3 rr_ptr wrap", dut.rr_ptr_q, 1);
            step();
        end
        req = '0;

        // Strict priority (HOLD_MAX=0): port 1 starves; also exercises the perf counter.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("t4 gnt_z c%0d", i), gnt_z, 4'b0001);
            if (i > 0) chk($sformatf("t4 rvalid_z c%0d", i), rvalid_z, 4'b0001);
            if (i == 10) chk("t4 cnt 10", cnt, PERF ? 10 : 0);
            step();
        end
        req = '0;
        @(negedge clk);
        chk("t4 rvalid_z last", rvalid_z, 4'b0001);
        chk("t4 cnt_z 20", cnt_z, PERF ? 20 : 0);

        // Port 3 write, then reset lands before its response.
        step();
        req = 4'b1000;
        we[3] = 1'b1;
        be[3*BW +: BW] = 4'hF;
        wdata[3*DW +: DW] = 32'hCAFEF00D;
        addr[3*AW +: AW] = 32'h3300;
        @(negedge clk);
        chk("t5 gnt", gnt, 4'b1000);
        chk("t5 ram_we", ram_we, 1);
        chk("t5 ram_be", ram_be, 4'hF);
        chk("t5 ram_wdata", ram_wdata, 32'hCAFEF00D);
        chk("t5 ram_addr", ram_addr, 32'h3300);
        step();
        rst = 1'b1;
        req = '0;
        we = '0;
        @(negedge clk);
        chk("t5 rvalid in rst", rvalid, 0);
        chk("t5 gnt in rst", gnt, 0);
        step();
        rst = 1'b0;
        req = 4'b1100;
        @(negedge clk);
        chk("t5 rvalid after", rvalid, 0);
        chk("t5 rr_ptr", dut.rr_ptr_q, 1);
        chk("t5 gnt port2", gnt, 4'b0100);
        step();
        req = '0;
        @(negedge clk);
        chk("t5 rvalid port2", rvalid, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
